dmc_encode: RTL
===============

DMC_ENCODE -- requirements
Module: dmc_encode

Interface
REQ-001 SHALL have parameter FRAME_LEN_W, default 8, width of the frame-length input (data bits per frame).
REQ-002 SHALL have parameter HB_W, default 8, width of the half-bit-period input in clk_i cycles.
REQ-003 SHALL have port clk_i, input, 1, system clock, all logic rising-edge; reset is reset_n_period, asynchronous, active-low.
REQ-004 SHALL have port reset_n_period, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1; low forces abort to idle.
REQ-006 SHALL have port start, input, 1, single-cycle frame request.
REQ-007 SHALL have port half_bit_len, input, HB_W, half-bit period H in clk_i cycles.
REQ-008 SHALL have port frame_len, input, FRAME_LEN_W, data bits per frame N.
REQ-009 SHALL have port tx_data, input, 1, next data bit.
REQ-010 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-011 SHALL have port tx_ready, output, 1, encoder accepts tx_data this cycle.
REQ-012 SHALL have port line_o, output, 1, registered differential-Manchester line level.
REQ-013 SHALL have ports busy, done, cfg_err, underrun: outputs, 1 each (frame active; end pulse; bad-config pulse; sticky underrun flag).

Function
REQ-014 SHALL implement states IDLE, SYNC, DATA, PARITY, END; IDLE->SYNC on accepted start, SYNC->DATA after 6H cycles, DATA->PARITY or END after N cells, END->IDLE after one cycle.
REQ-015 SHALL accept start only in IDLE with enable=1, H>=2, N!=0; start while busy is ignored with no side effect.
REQ-016 SHALL pulse cfg_err one cycle when start arrives in IDLE with enable=1 and H<2 or N=0, and stay in IDLE.
REQ-017 SHALL latch H and N at accepted start; later input changes do not affect the current frame.
REQ-018 SHALL toggle line_o first in the cycle after accepted start (t0 = start cycle + 1); busy rises in that same cycle.
REQ-019 SHALL emit sync as two 3H-cycle intervals: toggles at t0 and t0+3H; first data cell starts at t0+6H.
REQ-020 SHALL toggle line_o at every cell start (cell = 2H cycles); bit 0 additionally toggles at cell start + H; bit 1 has no mid-cell toggle.
REQ-021 SHALL assert tx_ready for exactly one cycle, the cycle before each data cell start; the bit is captured when tx_valid=1 in that cycle.
REQ-022 SHALL, if tx_valid=0 during the tx_ready cycle, encode bit 0 and set underrun; underrun clears only on the next accepted start or reset.
REQ-023 SHALL, after the last cell, toggle line_o once more (terminating edge) at cell end, pulse done in that cycle, and deassert busy in the following cycle.
REQ-024 SHALL use a half-bit counter of HB_W bits counting 0..H-1 and a bit counter of FRAME_LEN_W bits; no wrap beyond latched values.
REQ-025 SHALL, on enable=0 in any non-IDLE state, go to IDLE next cycle: busy=0, no done, tx_ready=0, line_o holds its level.
REQ-026 SHALL give enable-abort priority over a simultaneous end-of-frame; done is not pulsed.

Reset
REQ-027 SHALL reset asynchronously to IDLE with line_o=0, busy=0, done=0, tx_ready=0, cfg_err=0, underrun=0, all counters 0.
REQ-028 SHALL, on reset mid-frame, drop all outputs to reset values immediately without a terminating edge.

Configuration
REQ-029 SHALL support macro DMC_ENCODE_PARITY_EN: defined -> PARITY state inserts one extra cell after the last data bit carrying even parity (XOR of the N encoded bits), no tx_ready for it; undefined -> DATA goes directly to END and PARITY is unreachable.

Verification
REQ-030 H=4, N=4, bits 1,0,1,1, macro undefined, start at cycle 0 -> line toggles at 1,13,25,33,37,41,49,57; tx_ready at 24,32,40,48; done at 57.
REQ-031 Same stimulus, DMC_ENCODE_PARITY_EN defined -> parity cell (value 1) toggles at 57 only, terminating toggle and done at 65.
REQ-032 H=4, N=2, tx_valid=0 at first tx_ready -> first cell has mid toggle (bit 0), underrun=1 until next start.
REQ-033 start with H=1 or N=0 -> cfg_err single pulse, busy stays 0, line_o unchanged.
REQ-034 enable dropped at cycle 30 of REQ-030 frame -> busy=0 at 31, no further toggles, no done; second start during busy ignored.
REQ-035 reset_n_period asserted mid-DATA -> line_o=0, busy=0, underrun=0 asynchronously; next start encodes normally.

Source files
------------

// File: rtl/dmc_encode_if.sv
// Handshake/configuration bundle for the differential-Manchester encoder.
// master drives the request side; slave is the encoder.
interface dmc_encode_if #(
  parameter int FRAME_LEN_W = 8,
  parameter int HB_W        = 8
);
  logic                   enable;
  logic                   start;
  logic [HB_W-1:0]        half_bit_len;
  logic [FRAME_LEN_W-1:0] frame_len;
  logic                   tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   line_o;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;
  logic                   underrun;

  modport master (
    output enable, start, half_bit_len, frame_len, tx_data, tx_valid,
    input  tx_ready, line_o, busy, done, cfg_err, underrun
  );

  modport slave (
    input  enable, start, half_bit_len, frame_len, tx_data, tx_valid,
    output tx_ready, line_o, busy, done, cfg_err, underrun
  );
endinterface

// File: rtl/dmc_encode.sv
// Differential-Manchester frame encoder: sync preamble, N data cells, optional
// even-parity cell (macro DMC_ENCODE_PARITY_EN), terminating edge.
module dmc_encode #(
  parameter int FRAME_LEN_W = 8,
  parameter int HB_W        = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_period,
  dmc_encode_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [HB_W-1:0]        hb_q, hb_d, h_q, h_d;
  logic [FRAME_LEN_W-1:0] bit_q, bit_d, n_q, n_d;
  logic [2:0]             half_q, half_d;
  logic                   cur_bit_q, cur_bit_d;
  logic                   par_q, par_d;
  logic                   line_q, line_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   underrun_q, underrun_d;
  logic                   start_req_s, cfg_ok_s, hb_wrap_s, toggle_s;

  function automatic logic even_par_acc(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // Next-state and counter sequencing; all outputs are decoded from the next state.
  always_comb begin
    state_d    = state_q;
    hb_d       = hb_q;
    half_d     = half_q;
    bit_d      = bit_q;
    h_d        = h_q;
    n_d        = n_q;
    cur_bit_d  = cur_bit_q;
    par_d      = par_q;
    underrun_d = underrun_q;
    toggle_s   = 1'b0;

    start_req_s = (state_q == S_IDLE) && bus.enable && bus.start;
    cfg_ok_s    = (bus.half_bit_len >= HB_W'(2)) && (bus.frame_len != '0);
    hb_wrap_s   = (hb_q == (h_q - HB_W'(1)));
    cfg_err_d   = start_req_s && !cfg_ok_s;

    // Bit offered in the tx_ready cycle; a missing bit encodes as 0.
    if (tx_ready_q && bus.enable) begin
      cur_bit_d  = bus.tx_valid & bus.tx_data;
      par_d      = even_par_acc(par_q, bus.tx_valid & bus.tx_data);
      underrun_d = underrun_q | ~bus.tx_valid;
    end else begin
      cur_bit_d  = cur_bit_q;
    end

    if ((state_q != S_IDLE) && !bus.enable) begin
      state_d = S_IDLE;
      hb_d    = '0;
      half_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_req_s && cfg_ok_s) begin
            state_d    = S_SYNC;
            h_d        = bus.half_bit_len;
            n_d        = bus.frame_len;
            hb_d       = '0;
            half_d     = '0;
            bit_d      = '0;
            par_d      = 1'b0;
            underrun_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SYNC: begin
          if (hb_wrap_s) begin
            hb_d = '0;
            if (half_q == 3'd5) begin
              state_d = S_DATA;
              half_d  = '0;
            end else begin
              half_d = half_q + 3'd1;
            end
          end else begin
            hb_d = hb_q + HB_W'(1);
          end
        end
        S_DATA, S_PARITY: begin
          if (hb_wrap_s) begin
            hb_d = '0;
            if (half_q == 3'd1) begin
              half_d = '0;
              if (state_q == S_PARITY) begin
                state_d = S_END;
              end else if (bit_q == (n_q - FRAME_LEN_W'(1))) begin
`ifdef DMC_ENCODE_PARITY_EN
                state_d   = S_PARITY;
                cur_bit_d = par_q;
`else
                state_d   = S_END;
`endif
              end else begin
                bit_d = bit_q + FRAME_LEN_W'(1);
              end
            end else begin
              half_d = 3'd1;
            end
          end else begin
            hb_d = hb_q + HB_W'(1);
          end
        end
        S_END: begin
          state_d = S_IDLE;
          hb_d    = '0;
          half_d  = '0;
          bit_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          hb_d    = '0;
          half_d  = '0;
          bit_d   = '0;
        end
      endcase
    end

    // Half-bit counter at zero marks an interval boundary in the coming cycle.
    case (state_d)
      S_SYNC:           toggle_s = (hb_d == '0) && ((half_d == 3'd0) || (half_d == 3'd3));
      S_DATA, S_PARITY: toggle_s = (hb_d == '0) && ((half_d == 3'd0) || !cur_bit_d);
      S_END:            toggle_s = 1'b1;
      default:          toggle_s = 1'b0;
    endcase

    line_d     = line_q ^ toggle_s;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_END);
    tx_ready_d = ((state_d == S_SYNC) && (half_d == 3'd5) && (hb_d == (h_d - HB_W'(1)))) ||
                 ((state_d == S_DATA) && (half_d == 3'd1) && (hb_d == (h_d - HB_W'(1))) &&
                  (bit_d != (n_d - FRAME_LEN_W'(1))));
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_period) begin
    if (!reset_n_period) begin
      state_q    <= S_IDLE;
      hb_q       <= '0;
      half_q     <= '0;
      bit_q      <= '0;
      h_q        <= '0;
      n_q        <= '0;
      cur_bit_q  <= 1'b0;
      par_q      <= 1'b0;
      line_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hb_q       <= hb_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      h_q        <= h_d;
      n_q        <= n_d;
      cur_bit_q  <= cur_bit_d;
      par_q      <= par_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ready_q <= tx_ready_d;
      cfg_err_q  <= cfg_err_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.line_o   = line_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.underrun = underrun_q;

endmodule
